// File: rtl/sched_pkg.sv
// Shared types and helpers for the irrigation scheduler.
// The optional watchdog (macro SCHED_WATCHDOG_EN) is used in irrigation_scheduler.sv.
package sched_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EVAL     = 3'd1,
      RUN      = 3'd2,
      RELEASE  = 3'd3,
      COOLDOWN = 3'd4
   } sched_state_t;

   localparam logic [7:0] DEF_MIN_DUR  = 8'd2;
   localparam logic [7:0] DEF_MAX_DUR  = 8'd200;
   localparam logic [7:0] DEF_SOAK_DUR = 8'd10;

   // Saturate a 9-bit value into the window [lo, hi].
   function automatic logic [7:0] clamp8(input logic [8:0] x,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      if (x < {1'b0, lo})
         return lo;
      else if (x > {1'b0, hi})
         return hi;
      else
         return x[7:0];
   endfunction

endpackage

// File: rtl/sched_duration_calc.sv
// Combinational phase-length calculation from one moisture/temperature sample.
// The result is registered by the parent while it is in EVAL.
module sched_duration_calc
   import sched_pkg::*;
#(
   parameter logic [7:0] MOIST_TARGET = 8'd128,
   parameter logic [7:0] TEMP_THRESH  = 8'd30,
   parameter logic [7:0] SOAK_DUR     = DEF_SOAK_DUR,
   parameter logic [7:0] MIN_DUR      = DEF_MIN_DUR,
   parameter logic [7:0] MAX_DUR      = DEF_MAX_DUR
) (
   input  logic [7:0] moisture,
   input  logic [7:0] temperature,
   output logic [7:0] state1,
   output logic [7:0] state2,
   output logic [7:0] state3
);

   logic [8:0] moist_deficit;
   logic [8:0] heat_excess;

   // Irrigate for the moisture deficit, ventilate for twice the heat excess;
   // the doubling is done in 9 bits so it saturates at the clamp, not by wrapping.
   always_comb begin
      moist_deficit = 9'd0;
      heat_excess   = 9'd0;
      if (moisture < MOIST_TARGET)
         moist_deficit = {1'b0, 8'(MOIST_TARGET - moisture)};
      if (temperature > TEMP_THRESH)
         heat_excess = {8'(temperature - TEMP_THRESH), 1'b0};
      state1 = clamp8(moist_deficit, MIN_DUR, MAX_DUR);
      state2 = SOAK_DUR;
      state3 = (temperature > TEMP_THRESH) ? clamp8(heat_excess, MIN_DUR, MAX_DUR) : MIN_DUR;
   end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: decides when a watering cycle is needed, computes the
// three phase durations and handshakes with the downstream sequencer.
// Optional macro SCHED_WATCHDOG_EN adds a RUN-phase watchdog and a sticky fault output.
module irrigation_scheduler
   import sched_pkg::*;
#(
   parameter logic [7:0]  MOIST_TARGET    = 8'd128,
   parameter logic [7:0]  TEMP_THRESH     = 8'd30,
   parameter logic [7:0]  SOAK_DUR        = DEF_SOAK_DUR,
   parameter logic [7:0]  MIN_DUR         = DEF_MIN_DUR,
   parameter logic [7:0]  MAX_DUR         = DEF_MAX_DUR,
   parameter logic [15:0] COOLDOWN_CYCLES = 16'd100
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sample_valid,
   input  logic [7:0] moisture,
   input  logic [7:0] temperature,
   input  logic       start_req,
   input  logic       seq_done,
   output logic       seq_enable,
   output logic [7:0] state1_duration,
   output logic [7:0] state2_duration,
   output logic [7:0] state3_duration,
   output logic       busy,
   output logic [7:0] cycle_count
`ifdef SCHED_WATCHDOG_EN
   ,
   output logic       fault
`endif
);

   localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 16'd1);

   sched_state_t state, state_next;
   logic [7:0]   moist_held, temp_held;
   logic         sample_seen;
   logic [15:0]  cool_cnt;
   logic         trigger;
   logic         aborted;
   logic [7:0]   calc_d1, calc_d2, calc_d3;

   assign trigger    = sample_valid && ((moisture < MOIST_TARGET) || (temperature > TEMP_THRESH));
   assign seq_enable = (state == RUN);
   assign busy       = (state != IDLE);

   // Held sample is zero until the first capture; gate with sample_seen to make that explicit.
   sched_duration_calc #(
      .MOIST_TARGET (MOIST_TARGET),
      .TEMP_THRESH  (TEMP_THRESH),
      .SOAK_DUR     (SOAK_DUR),
      .MIN_DUR      (MIN_DUR),
      .MAX_DUR      (MAX_DUR)
   ) u_calc (
      .moisture    (sample_seen ? moist_held : 8'd0),
      .temperature (sample_seen ? temp_held  : 8'd0),
      .state1      (calc_d1),
      .state2      (calc_d2),
      .state3      (calc_d3)
   );

`ifdef SCHED_WATCHDOG_EN
   localparam logic [9:0] WD_LAST = 10'(3 * MAX_DUR + 16 - 1);
   logic [9:0] wd_cnt;
   logic       wd_expire;

   assign wd_expire = (state == RUN) && !seq_done && (wd_cnt == WD_LAST);

   // Count RUN cycles; flag a sticky fault and mark the cycle as aborted on expiry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt  <= '0;
         fault   <= 1'b0;
         aborted <= 1'b0;
      end else begin
         wd_cnt <= (state == RUN) ? wd_cnt + 10'd1 : 10'd0;
         if (wd_expire) begin
            fault   <= 1'b1;
            aborted <= 1'b1;
         end else if (state == EVAL) begin
            aborted <= 1'b0;
         end
      end
   end
`else
   assign aborted = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start_req || trigger) state_next = EVAL;
         EVAL:     state_next = RUN;
`ifdef SCHED_WATCHDOG_EN
         RUN:      if (seq_done || wd_expire) state_next = RELEASE;
`else
         RUN:      if (seq_done) state_next = RELEASE;
`endif
         RELEASE:  if (!seq_done) state_next = COOLDOWN;
         COOLDOWN: if (cool_cnt == COOL_LAST) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Capture every valid sample regardless of state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         moist_held  <= '0;
         temp_held   <= '0;
         sample_seen <= 1'b0;
      end else if (sample_valid) begin
         moist_held  <= moisture;
         temp_held   <= temperature;
         sample_seen <= 1'b1;
      end
   end

   // Latch durations once in EVAL; they stay stable through RUN and beyond.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state1_duration <= MIN_DUR;
         state2_duration <= MIN_DUR;
         state3_duration <= MIN_DUR;
      end else if (state == EVAL) begin
         state1_duration <= calc_d1;
         state2_duration <= calc_d2;
         state3_duration <= calc_d3;
      end
   end

   // Count cycles completed by a real seq_done handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cycle_count <= '0;
      else if ((state == RELEASE) && !seq_done && !aborted)
         cycle_count <= cycle_count + 8'd1;
   end

   // Cooldown counter runs 0..COOLDOWN_CYCLES-1 while in COOLDOWN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cool_cnt <= '0;
      else if ((state == COOLDOWN) && (cool_cnt != COOL_LAST))
         cool_cnt <= cool_cnt + 16'd1;
      else
         cool_cnt <= '0;
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_irrigation_scheduler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] moisture = 8'd0;
   logic [7:0] temperature = 8'd0;
   logic       start_req = 1'b0;
   logic       seq_done = 1'b0;
   logic       seq_enable;
   logic [7:0] state1_duration, state2_duration, state3_duration;
   logic       busy;
   logic [7:0] cycle_count;
`ifdef SCHED_WATCHDOG_EN
   logic       fault;
`endif

   irrigation_scheduler dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sample_valid    (sample_valid),
      .moisture        (moisture),
      .temperature     (temperature),
      .start_req       (start_req),
      .seq_done        (seq_done),
      .seq_enable      (seq_enable),
      .state1_duration (state1_duration),
      .state2_duration (state2_duration),
      .state3_duration (state3_duration),
      .busy            (busy),
      .cycle_count     (cycle_count)
`ifdef SCHED_WATCHDOG_EN
      ,
      .fault           (fault)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_EVAL = 1, P_RUN = 2, P_REL = 3, P_COOL = 4;
   int m_phase = P_IDLE;
   int m_cool = 0;
   int m_d1 = 2, m_d2 = 2, m_d3 = 2;
   int m_count = 0;
   int m_moist = 0, m_temp = 0;
   int m_abort = 0;
`ifdef SCHED_WATCHDOG_EN
   int m_wd = 0;
   int m_fault = 0;
`endif

   function automatic int clampi(input int x);
      if (x < 2) return 2;
      if (x > 200) return 200;
      return x;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_cool = 0;
      m_d1 = 2; m_d2 = 2; m_d3 = 2;
      m_count = 0; m_moist = 0; m_temp = 0; m_abort = 0;
`ifdef SCHED_WATCHDOG_EN
      m_wd = 0; m_fault = 0;
`endif
   endtask

   task automatic model_step();
      case (m_phase)
         P_IDLE: if (start_req || (sample_valid && (int'(moisture) < 128 || int'(temperature) > 30)))
                    m_phase = P_EVAL;
         P_EVAL: begin
            m_d1 = clampi(m_moist < 128 ? 128 - m_moist : 0);
            m_d2 = 10;
            m_d3 = (m_temp > 30) ? clampi(2 * (m_temp - 30)) : 2;
            m_abort = 0;
`ifdef SCHED_WATCHDOG_EN
            m_wd = 0;
`endif
            m_phase = P_RUN;
         end
         P_RUN: begin
            if (seq_done) m_phase = P_REL;
`ifdef SCHED_WATCHDOG_EN
            else begin
               m_wd++;
               if (m_wd >= 616) begin m_phase = P_REL; m_fault = 1; m_abort = 1; end
            end
`endif
         end
         P_REL: if (!seq_done) begin
            if (m_abort == 0) m_count = (m_count + 1) % 256;
            m_phase = P_COOL;
            m_cool = 100;
         end
         P_COOL: begin
            m_cool--;
            if (m_cool == 0) m_phase = P_IDLE;
         end
         default: m_phase = P_IDLE;
      endcase
      if (sample_valid) begin
         m_moist = int'(moisture);
         m_temp  = int'(temperature);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
   end

   // Every-cycle comparison of DUT outputs against the model.
   initial forever begin
      @(negedge clk);
      check("cyc_seq_enable", int'(seq_enable), (m_phase == P_RUN) ? 1 : 0);
      check("cyc_busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
      check("cyc_count", int'(cycle_count), m_count);
      check("cyc_d1", int'(state1_duration), m_d1);
      check("cyc_d2", int'(state2_duration), m_d2);
      check("cyc_d3", int'(state3_duration), m_d3);
`ifdef SCHED_WATCHDOG_EN
      check("cyc_fault", int'(fault), m_fault);
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic strobe(input int m, input int t);
      @(posedge clk); #1;
      sample_valid = 1'b1; moisture = 8'(m); temperature = 8'(t);
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("wait_idle", int'(busy), 0);
   endtask

   int n;

   initial begin
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_enable", int'(seq_enable), 0);
      check("rst_d1", int'(state1_duration), 2);
      check("rst_d2", int'(state2_duration), 2);
      check("rst_count", int'(cycle_count), 0);

      // Sample at target with no heat: no trigger.
      strobe(128, 30);
      @(negedge clk);
      check("no_trigger_busy", int'(busy), 0);

      // moisture=100, temp=25: EVAL at T+1, RUN at T+2 with 28/10/2.
      strobe(100, 25);
      @(negedge clk);
      check("t1_eval_busy", int'(busy), 1);
      check("t1_eval_enable", int'(seq_enable), 0);
      @(negedge clk);
      check("t1_run_enable", int'(seq_enable), 1);
      check("t1_d1", int'(state1_duration), 28);
      check("t1_d2", int'(state2_duration), 10);
      check("t1_d3", int'(state3_duration), 2);
      @(posedge clk); #1 seq_done = 1'b1;
      @(posedge clk); #1 seq_done = 1'b0;
      @(negedge clk);
      check("t1_done_drop", int'(seq_enable), 0);
      @(negedge clk);
      check("t1_count", int'(cycle_count), 1);
      // Cooldown length, with start_req held for most of it.
      start_req = 1'b1;
      n = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n == 90) start_req = 1'b0;
      end
      check("t1_cooldown_len", n, 100);
      @(negedge clk);
      check("t1_start_ignored", int'(busy), 0);

      // moisture=200, temp=50: 2/10/40, seq_done held 3 cycles.
      strobe(200, 50);
      @(negedge clk);
      @(negedge clk);
      check("t2_d1", int'(state1_duration), 2);
      check("t2_d3", int'(state3_duration), 40);
      @(posedge clk); #1 seq_done = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1 seq_done = 1'b0;
      @(negedge clk);
      check("t2_hold_busy", int'(busy), 1);
      check("t2_hold_count", int'(cycle_count), 1);
      @(negedge clk);
      check("t2_count", int'(cycle_count), 2);
      wait_idle();

      // Extreme sample: 128/10/200, then async reset while in RUN.
      strobe(0, 255);
      @(negedge clk);
      @(negedge clk);
      check("t3_d1", int'(state1_duration), 128);
      check("t3_d2", int'(state2_duration), 10);
      check("t3_d3", int'(state3_duration), 200);
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      check("arst_enable", int'(seq_enable), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_count", int'(cycle_count), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("arst_idle", int'(busy), 0);

`ifdef SCHED_WATCHDOG_EN
      // Stuck sequencer: watchdog aborts after 616 RUN cycles.
      @(posedge clk); #1 start_req = 1'b1;
      @(posedge clk); #1 start_req = 1'b0;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (seq_enable) n++;
         else if (n > 0) break;
      end
      check("wd_run_len", n, 616);
      check("wd_fault", int'(fault), 1);
      check("wd_count", int'(cycle_count), 0);
      repeat (150) @(negedge clk);
      check("wd_fault_sticky", int'(fault), 1);
`endif

      // Randomized traffic checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         sample_valid = ($urandom_range(0, 3) == 0);
         moisture     = 8'($urandom_range(0, 255));
         temperature  = 8'($urandom_range(0, 255));
         start_req    = ($urandom_range(0, 15) == 0);
         seq_done     = ($urandom_range(0, 5) == 0);
      end
      @(posedge clk); #1;
      sample_valid = 1'b0; start_req = 1'b0; seq_done = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
